trap_event_sequencer: RTL and testbench
=======================================

Name: trap_event_sequencer

Overview:
Event sequencer that sits downstream of the trapezoidal shaping filter.
- Watches the shaped stream for a rising threshold crossing, then waits out the filter rise time.
- Averages the flat-top samples and emits one amplitude + timestamp record per pulse over a valid/ready interface.
- Enforces a holdoff window and counts events it cannot deliver.

Parameters:
- DATA_W, 16: width of filt_data and ev_amp, signed.
- TS_W, 32: timestamp counter width.
- RISE_CYC, 8: cycles from trigger to first flat-top sample; legal range 1..255.
- FLAT_CYC, 4: flat-top samples averaged; power of two, 1..16.
- HOLDOFF_CYC, 32: dead time after sampling; legal range 1..1023.
- PILEUP_TOL, 200: max allowed flat-top spread; used only with the optional feature.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-low reset.
- en, input, 1: arm enable.
- threshold, input, DATA_W: signed trigger level, sampled every cycle.
- filt_data, input, DATA_W: signed shaped filter output.
- ev_valid, output, 1: event record valid.
- ev_ready, input, 1: downstream accept.
- ev_amp, output, DATA_W: signed flat-top average.
- ev_ts, output, TS_W: timestamp of trigger.
- busy, output, 1: high in RISE, SAMPLE or HOLD.
- drop_cnt, output, 16: events lost to backpressure; saturating.
- pileup_cnt, output, 16: events rejected as pile-up; saturating.

Behaviour:
Reset and timestamp:
- Reset is synchronous, active-low (reset=0 resets); clock clk.
- On reset: state=IDLE; ev_valid, ev_amp, ev_ts, drop_cnt, pileup_cnt, timestamp counter, accumulator = 0; prev_sample = most positive DATA_W value, so no false crossing can occur on the first cycle after reset.
- Reset asserted mid-event aborts the event: no record is emitted and no counter is incremented.
- Timestamp counter increments every non-reset cycle and wraps modulo 2^TS_W.
- prev_sample <= filt_data every non-reset cycle, in every state.

Crossing and states:
- Crossing = (filt_data > threshold) && (prev_sample <= threshold), signed strict compare.
- IDLE: when en=1, go to ARMED next edge.
- ARMED: on a crossing at edge T, latch ts_latch = counter value at T, cnt = RISE_CYC-1, go to RISE.
- RISE: decrement cnt; at cnt=0 go to SAMPLE with acc=0, min/max cleared, cnt = FLAT_CYC-1.
- SAMPLE: acc += sign-extended filt_data, with acc width DATA_W+4. Samples are taken at edges T+RISE_CYC+1 .. T+RISE_CYC+FLAT_CYC.
- On the last sample edge: avg = (acc + sample) >>> log2(FLAT_CYC), arithmetic shift, truncated to DATA_W.
  - If the output slot is free (ev_valid=0, or ev_valid & ev_ready this edge): load ev_amp = avg, ev_ts = ts_latch, ev_valid = 1.
  - Otherwise: increment drop_cnt and leave the pending record untouched.
  - Then go to HOLD with cnt = HOLDOFF_CYC-1.
- HOLD: crossings are ignored; decrement cnt; at 0 go to ARMED. A crossing requires a fresh below-to-above transition after HOLD.
- en=0 in ARMED/RISE/SAMPLE/HOLD: go to IDLE next edge and discard any partial event. A pending ev_valid record is still held until it is accepted.

Handshake and latency:
- Transfer occurs on an edge with ev_valid & ev_ready. ev_valid clears unless a new record loads on the same edge; a new record wins.
- ev_amp/ev_ts are stable while ev_valid=1 and ev_ready=0.
- Latency: ev_valid is first visible in the cycle after edge T+RISE_CYC+FLAT_CYC.

Optional Feature:
Macro: TRAP_SEQ_PILEUP_REJECT_EN.
- Defined: track min/max of filt_data during SAMPLE. If max-min > PILEUP_TOL, suppress the record, increment pileup_cnt (saturating), and still enter HOLD.
- Undefined: no min/max logic; every sampled event is emitted or dropped; pileup_cnt is tied to 0.

Test Plan:
Default parameters, threshold=100, en=1, ev_ready=1 unless stated.
1. filt_data steps 0->1000 at edge T with counter=50 -> ev_valid first visible in the cycle after edge T+12; ev_amp=1000, ev_ts=50; busy high from T+1 through end of HOLD.
2. filt_data=100 held, then 101 -> no trigger at 100; trigger on 101; ev_amp=101.
3. ev_ready=0; two pulses of 500 and 800, 60 cycles apart -> ev_amp stays 500, drop_cnt=1. Raise ev_ready -> one transfer, then ev_valid=0.
4. Second crossing 20 cycles after the first sample edge (inside HOLD) -> ignored. Crossing after HOLD ends -> second record with the new ts.
5. Reset pulled low during SAMPLE -> next cycle all outputs 0, state IDLE, no record; a pulse after release is captured normally.
6. Flat-top samples 1000,1000,1300,1300 -> with macro: no record, pileup_cnt=1. Without macro: ev_amp=1150. Separately, samples of -400 x4 -> ev_amp=-400.

Source files
------------

// File: rtl/trap_event_sequencer.sv
// Trapezoid event sequencer: threshold trigger, flat-top averaging, holdoff.
// Optional pile-up rejection enabled by defining TRAP_SEQ_PILEUP_REJECT_EN.
module trap_event_sequencer #(
    parameter int DATA_W      = 16,
    parameter int TS_W        = 32,
    parameter int RISE_CYC    = 8,
    parameter int FLAT_CYC    = 4,
    parameter int HOLDOFF_CYC = 32,
    parameter int PILEUP_TOL  = 200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic signed [DATA_W-1:0] filt_data,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic signed [DATA_W-1:0] ev_amp,
    output logic [TS_W-1:0]          ev_ts,
    output logic                     busy,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              pileup_cnt
);

    localparam int ACC_W     = DATA_W + 4;
    localparam int LOG2_FLAT = $clog2(FLAT_CYC);
    localparam int CNT_W     = 10;

    localparam logic signed [DATA_W-1:0] MAX_POS =
        {1'b0, {(DATA_W-1){1'b1}}};

    if (RISE_CYC < 1 || RISE_CYC > 255 ||
        FLAT_CYC < 1 || FLAT_CYC > 16 ||
        (FLAT_CYC & (FLAT_CYC - 1)) != 0 ||
        HOLDOFF_CYC < 1 || HOLDOFF_CYC > 1023 ||
        PILEUP_TOL < 0) begin : g_bad_param
        $error("trap_event_sequencer: illegal parameter");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RISE,
        S_SAMPLE,
        S_HOLD
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic signed [ACC_W-1:0]   acc, acc_n, sum;
    logic [TS_W-1:0]           ts_cnt, ts_latch;
    logic signed [DATA_W-1:0]  prev_sample;
    logic                      crossing, slot_free, reject;
    logic                      latch, emit, drop, rej_ev;

    assign crossing  = (filt_data > threshold) &&
                       (prev_sample <= threshold);
    assign sum       = acc + ACC_W'(filt_data);
    assign slot_free = !ev_valid || ev_ready;
    assign busy      = (state == S_RISE) || (state == S_SAMPLE) ||
                       (state == S_HOLD);

`ifdef TRAP_SEQ_PILEUP_REJECT_EN
    localparam logic signed [DATA_W-1:0] MIN_NEG =
        {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] mn, mx, mn_n, mx_n;
    logic signed [DATA_W:0]   spread;

    assign mn_n   = (filt_data < mn) ? filt_data : mn;
    assign mx_n   = (filt_data > mx) ? filt_data : mx;
    assign spread = (DATA_W+1)'(mx_n) - (DATA_W+1)'(mn_n);
    assign reject = spread > (DATA_W+1)'(PILEUP_TOL);

    // Extremes restart every time the flat-top window opens.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mn         <= MAX_POS;
            mx         <= MIN_NEG;
            pileup_cnt <= '0;
        end else begin
            if (state != S_SAMPLE) begin
                mn <= MAX_POS;
                mx <= MIN_NEG;
            end else begin
                mn <= mn_n;
                mx <= mx_n;
            end
            if (rej_ev && pileup_cnt != 16'hffff)
                pileup_cnt <= pileup_cnt + 16'd1;
        end
    end
`else
    assign reject     = 1'b0;
    assign pileup_cnt = '0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        latch   = 1'b0;
        emit    = 1'b0;
        drop    = 1'b0;
        rej_ev  = 1'b0;
        if (!en) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: state_n = S_ARMED;
                S_ARMED: begin
                    if (crossing) begin
                        state_n = S_RISE;
                        latch   = 1'b1;
                        cnt_n   = CNT_W'(RISE_CYC - 1);
                    end
                end
                S_RISE: begin
                    if (cnt == '0) begin
                        state_n = S_SAMPLE;
                        acc_n   = '0;
                        cnt_n   = CNT_W'(FLAT_CYC - 1);
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    acc_n = sum;
                    if (cnt == '0) begin
                        state_n = S_HOLD;
                        cnt_n   = CNT_W'(HOLDOFF_CYC - 1);
                        if (reject)
                            rej_ev = 1'b1;
                        else if (slot_free)
                            emit = 1'b1;
                        else
                            drop = 1'b1;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0)
                        state_n = S_ARMED;
                    else
                        cnt_n = cnt - CNT_W'(1);
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            ts_cnt      <= '0;
            ts_latch    <= '0;
            prev_sample <= MAX_POS;
            ev_valid    <= 1'b0;
            ev_amp      <= '0;
            ev_ts       <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            acc         <= acc_n;
            ts_cnt      <= ts_cnt + TS_W'(1);
            prev_sample <= filt_data;
            if (latch)
                ts_latch <= ts_cnt;
            // A freshly loaded record takes priority over the handshake clear.
            if (emit) begin
                ev_valid <= 1'b1;
                ev_amp   <= DATA_W'(sum >>> LOG2_FLAT);
                ev_ts    <= ts_latch;
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
            if (drop && drop_cnt != 16'hffff)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_trap_event_sequencer.sv
// Directed bench for trap_event_sequencer with hand-computed expectations.
// Expectations follow TRAP_SEQ_PILEUP_REJECT_EN when it is defined.
module tb_trap_event_sequencer;

    localparam int DATA_W = 16;
    localparam int TS_W   = 32;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     en = 1'b0;
    logic                     ev_ready = 1'b1;
    logic signed [DATA_W-1:0] threshold = 16'sd100;
    logic signed [DATA_W-1:0] filt_data = '0;
    logic                     ev_valid;
    logic                     busy;
    logic signed [DATA_W-1:0] ev_amp;
    logic [TS_W-1:0]          ev_ts;
    logic [15:0]              drop_cnt;
    logic [15:0]              pileup_cnt;

    int     checks = 0;
    int     errors = 0;
    longint ts_ref = 0;
    longint ts_exp = 0;

    always #5 clk = ~clk;

    trap_event_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .threshold  (threshold),
        .filt_data  (filt_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_amp     (ev_amp),
        .ev_ts      (ev_ts),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .pileup_cnt (pileup_cnt)
    );

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // ts_ref tracks the timestamp value presented at the next edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            ts_ref = reset ? ts_ref + 1 : 0;
            #1;
        end
    endtask

    task automatic fire(input logic signed [DATA_W-1:0] v);
        filt_data = v;
        ts_exp    = ts_ref;
        step(1);
    endtask

    task automatic settle();
        filt_data = '0;
        step(45);
    endtask

    initial begin
        en = 1'b1;
        step(3);
        chk("rst_valid", ev_valid, 0);
        chk("rst_amp", ev_amp, 0);
        chk("rst_ts", ev_ts, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_pileup", pileup_cnt, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // step to 1000 at the edge where the counter reads 50
        step(50);
        fire(16'sd1000);
        chk("t1_busy", busy, 1);
        step(11);
        chk("t1_early", ev_valid, 0);
        step(1);
        chk("t1_valid", ev_valid, 1);
        chk("t1_amp", ev_amp, 1000);
        chk("t1_ts", ev_ts, 50);
        step(1);
        chk("t1_xfer", ev_valid, 0);
        step(30);
        chk("t1_hold", busy, 1);
        step(1);
        chk("t1_done", busy, 0);

        // level equal to threshold must not trigger
        filt_data = '0;
        step(1);
        filt_data = 16'sd100;
        step(5);
        chk("t2_eq", busy, 0);
        fire(16'sd101);
        chk("t2_trig", busy, 1);
        step(12);
        chk("t2_valid", ev_valid, 1);
        chk("t2_amp", ev_amp, 101);
        chk("t2_ts", ev_ts, ts_exp);
        settle();

        // backpressure: second record dropped, first held
        ev_ready = 1'b0;
        fire(16'sd500);
        step(12);
        chk("t3_valid", ev_valid, 1);
        chk("t3_amp1", ev_amp, 500);
        filt_data = '0;
        step(47);
        fire(16'sd800);
        step(12);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_hold_v", ev_valid, 1);
        chk("t3_amp2", ev_amp, 500);
        chk("t3_ts", ev_ts, ts_exp - 60);
        ev_ready = 1'b1;
        step(1);
        chk("t3_xfer", ev_valid, 0);
        step(1);
        chk("t3_once", ev_valid, 0);
        settle();

        // crossing inside holdoff is ignored
        fire(16'sd600);
        step(12);
        chk("t4_amp1", ev_amp, 600);
        filt_data = '0;
        step(16);
        filt_data = 16'sd700;
        step(1);
        filt_data = '0;
        step(12);
        chk("t4_ignored", ev_valid, 0);
        chk("t4_busy", busy, 1);
        step(8);
        fire(16'sd900);
        step(12);
        chk("t4_valid", ev_valid, 1);
        chk("t4_amp2", ev_amp, 900);
        chk("t4_ts", ev_ts, ts_exp);
        settle();

        // reset in the middle of SAMPLE
        fire(16'sd400);
        step(9);
        reset = 1'b0;
        step(1);
        chk("t5_valid", ev_valid, 0);
        chk("t5_amp", ev_amp, 0);
        chk("t5_ts", ev_ts, 0);
        chk("t5_drop", drop_cnt, 0);
        chk("t5_busy", busy, 0);
        reset = 1'b1;
        step(14);
        chk("t5_norec", ev_valid, 0);
        filt_data = '0;
        step(1);
        fire(16'sd450);
        step(12);
        chk("t5_valid2", ev_valid, 1);
        chk("t5_amp2", ev_amp, 450);
        chk("t5_ts2", ev_ts, ts_exp);
        settle();

        // uneven flat top
        fire(16'sd1000);
        step(10);
        filt_data = 16'sd1300;
        step(2);
`ifdef TRAP_SEQ_PILEUP_REJECT_EN
        chk("t6_rej_v", ev_valid, 0);
        chk("t6_pileup", pileup_cnt, 1);
`else
        chk("t6_valid", ev_valid, 1);
        chk("t6_avg", ev_amp, 1150);
        chk("t6_pileup", pileup_cnt, 0);
`endif
        filt_data = -16'sd1000;
        threshold = -16'sd500;
        step(45);
        fire(-16'sd400);
        step(12);
        chk("t6_neg_v", ev_valid, 1);
        chk("t6_neg_amp", ev_amp, -400);
        chk("t6_neg_ts", ev_ts, ts_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
